// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader: FSM states
// and the byte/word geometry of the incoming program stream.
package loader_pkg;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream into little-endian words: byte k lands in bits
// [8k+7:8k]. word_ready flags the byte that completes a word.
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic [BYTE_W-1:0] data,
  output logic [WORD_W-1:0] word,
  output logic [CNT_W-1:0]  count,
  output logic              word_ready
);

  logic [WORD_W-1:0] shift_q;

  // New bytes enter at the top and slide down, so after four accepts the
  // first byte of the word sits in the least significant lane.
  assign word       = {data, shift_q[WORD_W-1:BYTE_W]};
  assign word_ready = accept && (count == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      count   <= '0;
    end else if (clear) begin
      shift_q <= '0;
      count   <= '0;
    end else if (accept) begin
      // NOTE: non-blocking assignments keep every register sampling
      // pre-edge values, so ordering inside the block cannot matter.
      shift_q <= word;
      count   <= count + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Receives a program as a byte stream and writes it word by word into
// instruction memory, stalling the CPU (busy) until the load is finished.
module imem_loader
  import loader_pkg::*;
#(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [INS_ADDRESS-1:0] num_words,
  input  logic                   in_valid,
  input  logic [BYTE_W-1:0]      in_data,
  output logic                   in_ready,
  output logic [31:0]            mem_waddr,
  output logic [INS_W-1:0]       mem_wdata,
  output logic                   mem_wr,
  output logic                   busy,
  output logic                   done
);

  state_t                 state_q;
  logic [INS_ADDRESS-1:0] word_index_q;
  logic [INS_ADDRESS-1:0] num_words_q;
  logic [INS_ADDRESS-1:0] next_index;
  logic [WORD_W-1:0]      packed_word;
  logic [CNT_W-1:0]       byte_count;
  logic                   word_ready;
  logic                   accept;
  logic                   start_load;

  // Status strobes decode straight from the state register, so they are
  // glitch-free and all drop to zero the moment reset asserts.
  assign in_ready   = (state_q == RECV);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign mem_wr     = (state_q == WRITE);

  assign accept     = in_valid && in_ready;
  assign start_load = (state_q == IDLE) && start;
  assign next_index = word_index_q + 1'b1;

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_load),
    .accept     (accept),
    .data       (in_data),
    .word       (packed_word),
    .count      (byte_count),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      word_index_q <= '0;
      num_words_q  <= '0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            num_words_q  <= num_words;
            word_index_q <= '0;
            state_q      <= (num_words == '0) ? DONE : RECV;
          end
        end
        RECV: begin
          // Write port is loaded on the completing byte so the data and
          // address are already stable for the whole WRITE cycle.
          if (word_ready) begin
            mem_wdata <= packed_word;
            mem_waddr <= 32'({word_index_q, 2'b00});
            state_q   <= WRITE;
          end
        end
        WRITE: begin
          word_index_q <= next_index;
          state_q      <= (next_index == num_words_q) ? DONE : RECV;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: single/multi-word loads, zero-length,
// stalled input, mid-load reset and ignored restarts.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  num_words;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          done_cnt = 0;
  int          ready_cnt = 0;
  int          busy_low_cnt = 0;
  bit          in_load = 1'b0;

  // Expected image of the 12-byte stream used by several tests.
  logic [7:0]  stream [12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                               8'h77, 8'h88, 8'h99, 8'haa, 8'hbb, 8'hcc};
  logic [31:0] exp_words [3] = '{32'h44332211, 32'h88776655, 32'hccbbaa99};

  imem_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_words (num_words),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_wr    (mem_wr),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wr) begin
      wr_addr_q.push_back(mem_waddr);
      wr_data_q.push_back(mem_wdata);
    end
    if (done) done_cnt++;
    if (in_ready) ready_cnt++;
    if (in_load && !busy) busy_low_cnt++;
  end

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt  = 0;
    ready_cnt = 0;
    busy_low_cnt = 0;
  endtask

  task automatic issue_start(input logic [8:0] n);
    start     = 1'b1;
    num_words = n;
    @(negedge clk);
    start     = 1'b0;
    num_words = 9'h1aa;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_byte: in_ready stuck low, got 0 expected 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'hxx;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val({name, "_done_seen"}, 32'(done), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_three_words(input string name);
    check_val({name, "_nwrites"}, 32'(wr_addr_q.size()), 32'd3);
    if (wr_addr_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check_val({name, "_addr"}, wr_addr_q[i], 32'(i * 4));
        check_val({name, "_data"}, wr_data_q[i], exp_words[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; num_words = '0; in_valid = 1'b0; in_data = '0;
    #12;
    check_val("rst_flags", {28'd0, mem_wr, in_ready, busy, done}, 32'd0);
    check_val("rst_waddr", mem_waddr, 32'd0);
    check_val("rst_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic test_one_word();
    clear_log();
    issue_start(9'd1);
    check_val("one_busy", 32'(busy), 32'd1);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check_val("one_wr",    32'(mem_wr), 32'd1);
    check_val("one_waddr", mem_waddr, 32'h0);
    check_val("one_wdata", mem_wdata, 32'h00000013);
    @(negedge clk);
    check_val("one_done",    32'(done), 32'd1);
    check_val("one_wr_off",  32'(mem_wr), 32'd0);
    check_val("one_hold",    mem_wdata, 32'h00000013);
    @(negedge clk);
    check_val("one_done_pulse", 32'(done), 32'd0);
    check_val("one_idle",       32'(busy), 32'd0);
    check_val("one_nwrites",    32'(wr_addr_q.size()), 32'd1);
  endtask

  task automatic test_three_words();
    clear_log();
    issue_start(9'd3);
    in_load = 1'b1;
    for (int i = 0; i < 12; i++) send_byte(stream[i]);
    wait_done("three");
    in_load = 1'b0;
    check_three_words("three");
    check_val("three_done_cnt", 32'(done_cnt), 32'd1);
    check_val("three_busy_low", 32'(busy_low_cnt), 32'd0);
  endtask

  task automatic test_zero_words();
    clear_log();
    issue_start(9'd0);
    check_val("zero_done", 32'(done), 32'd1);
    @(negedge clk);
    check_val("zero_done_pulse", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check_val("zero_nwrites", 32'(wr_addr_q.size()), 32'd0);
    check_val("zero_ready",   32'(ready_cnt), 32'd0);
  endtask

  task automatic test_gaps();
    clear_log();
    issue_start(9'd3);
    for (int i = 0; i < 12; i++) begin
      repeat (5) @(negedge clk);
      if (i == 2) check_val("gap_ready_hold", 32'(in_ready), 32'd1);
      send_byte(stream[i]);
    end
    wait_done("gap");
    check_three_words("gap");
    check_val("gap_done_cnt", 32'(done_cnt), 32'd1);
  endtask

  task automatic test_reset_mid_load();
    clear_log();
    issue_start(9'd2);
    send_byte(8'hde); send_byte(8'had);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_flags", {28'd0, mem_wr, in_ready, busy, done}, 32'd0);
    check_val("mid_rst_waddr", mem_waddr, 32'd0);
    check_val("mid_rst_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_val("mid_rst_nowrite", 32'(wr_addr_q.size()), 32'd0);
    check_val("mid_rst_idle",    32'(busy), 32'd0);
    issue_start(9'd1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    wait_done("mid_rst");
    check_val("mid_rst_nwrites", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() == 1) begin
      check_val("mid_rst_addr", wr_addr_q[0], 32'h0);
      check_val("mid_rst_data", wr_data_q[0], 32'h04030201);
    end
  endtask

  task automatic test_restart_ignored();
    clear_log();
    issue_start(9'd2);
    send_byte(8'h10); send_byte(8'h20);
    issue_start(9'd5);
    check_val("restart_busy", 32'(busy), 32'd1);
    send_byte(8'h30); send_byte(8'h40);
    issue_start(9'd7);
    send_byte(8'h50); send_byte(8'h60); send_byte(8'h70); send_byte(8'h80);
    wait_done("restart");
    repeat (10) @(negedge clk);
    check_val("restart_nwrites", 32'(wr_addr_q.size()), 32'd2);
    check_val("restart_done_cnt", 32'(done_cnt), 32'd1);
    if (wr_addr_q.size() == 2) begin
      check_val("restart_addr1", wr_addr_q[1], 32'h4);
      check_val("restart_data0", wr_data_q[0], 32'h40302010);
      check_val("restart_data1", wr_data_q[1], 32'h80706050);
    end
  endtask

  initial begin
    test_reset();
    test_one_word();
    test_three_words();
    test_zero_words();
    test_gaps();
    test_reset_mid_load();
    test_restart_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
